uart_rx: RTL

//  Serial receiver; the downstream counterpart of the UART transmitter. Samples RXD at the
//  16x baud tick 'enable', deframes start/data/parity/stop per LCR and emits one 11-bit word
//  per frame to the RX FIFO push interface, along with its error flags.

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: synchronises RXD, samples it mid-bit on the 16x tick and deframes
// start/data/parity/stop into {BI,FE,PE,data} words for the RX FIFO.
`timescale 1ns/1ps
module uart_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        RXD,
    input  logic        enable,
    input  logic [7:0]  LCR,
    input  logic        rx_fifo_full,
    output logic        rx_push,
    output logic [10:0] rx_word,
    output logic        overrun,
    output logic        busy,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_WAIT_HI = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rxs_prev_q, rxs_prev_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             data_q, data_d;
    // Frame format held for the whole frame: [4:3] parity type, [2] parity enable, [1:0] length.
    logic [4:0]             lcr_q, lcr_d;
    logic                   pe_q, pe_d;
    logic                   par_bit_q, par_bit_d;
    logic [10:0]            word_q, word_d;
    logic                   push_pend_q, push_pend_d;

    logic       rxs;
    logic       sample;
    logic       bit_end;
    logic [2:0] last_bit;
    logic       exp_par;
    logic       bi;
    logic       unused_lcr;

    assign unused_lcr = ^{LCR[7:6], LCR[2]};

    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], RXD};
        rxs      = sync_q[SYNC_STAGES-1];
        sample   = enable && (cnt_q == 4'd7);
        bit_end  = enable && (cnt_q == 4'd15);
        last_bit = {1'b0, lcr_q[1:0]} + 3'd4;
        case (lcr_q[4:3])
            2'b00:   exp_par = ~^data_q;
            2'b01:   exp_par = ^data_q;
            2'b10:   exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase
        // Break: the whole frame, parity bit included, was low.
        bi = (data_q == 8'd0) && (!lcr_q[2] || !par_bit_q) && !rxs;

        state_d     = state_q;
        rxs_prev_d  = rxs;
        cnt_d       = enable ? cnt_q + 4'd1 : cnt_q;
        bit_d       = bit_q;
        data_d      = data_q;
        lcr_d       = lcr_q;
        pe_d        = pe_q;
        par_bit_d   = par_bit_q;
        word_d      = word_q;
        push_pend_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = 4'd0;
                if (rxs_prev_q && !rxs) state_d = S_START;
            end
            S_START: begin
                if (sample) begin
                    if (rxs) begin
                        state_d = S_IDLE;
                    end else begin
                        lcr_d     = {LCR[5:3], LCR[1:0]};
                        data_d    = 8'd0;
                        pe_d      = 1'b0;
                        par_bit_d = 1'b0;
                        bit_d     = 3'd0;
                    end
                end
                if (bit_end) state_d = S_DATA;
            end
            S_DATA: begin
                if (sample) data_d[bit_q] = rxs;
                if (bit_end) begin
                    bit_d = bit_q + 3'd1;
                    if (bit_q == last_bit) state_d = lcr_q[2] ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (sample) begin
                    par_bit_d = rxs;
                    pe_d      = (rxs != exp_par);
                end
                if (bit_end) state_d = S_STOP;
            end
            S_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (sample) begin
                    word_d      = {bi, ~rxs, pe_q, data_q};
                    push_pend_d = 1'b1;
                    state_d     = rxs ? S_IDLE : S_WAIT_HI;
                end
            end
            S_WAIT_HI: begin
                if (rxs) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            sync_q      <= '1;
            rxs_prev_q  <= 1'b1;
            cnt_q       <= 4'd0;
            bit_q       <= 3'd0;
            data_q      <= 8'd0;
            lcr_q       <= 5'd0;
            pe_q        <= 1'b0;
            par_bit_q   <= 1'b0;
            word_q      <= 11'd0;
            push_pend_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            rxs_prev_q  <= rxs_prev_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            data_q      <= data_d;
            lcr_q       <= lcr_d;
            pe_q        <= pe_d;
            par_bit_q   <= par_bit_d;
            word_q      <= word_d;
            push_pend_q <= push_pend_d;
        end
    end

    // The FIFO full flag is looked at in the push cycle itself.
    assign rx_push   = push_pend_q & ~rx_fifo_full;
    assign overrun   = push_pend_q & rx_fifo_full;
    assign rx_word   = word_q;
    assign busy      = (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule
